iir_cascade: RTL

Parametrised cascade of first-order shift-coefficient IIR low-pass stages. It uses one time-multiplexed datapath that evaluates one stage per clock. It sits between the ADC sample path and the lock servo, and is started per sample by a `once` strobe with a `done` strobe on completion. Over the fixed two-stage filter it adds configurable stage count, guard bits for state precision, per-stage bypass, a synchronous state clear, and pipelined back-to-back acceptance.

---
 rtl/iir_cascade.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/iir_cascade.sv
// Cascade of first-order shift-coefficient IIR low-pass stages.
// A single time-multiplexed datapath evaluates one stage per clock.
// Each stage holds DATAWIDTH+GUARD bits of state and applies
//   s <= s + ((x - s) >>> a)
// The result always lies between s and x, so the update can never overflow.

// One stage update. Combinational; it is shared by every stage in turn.
module iir_stage_alu #(
  parameter int W      = 24,
  parameter int SHIFTW = 4
) (
  input  logic signed [W-1:0]      x,
  input  logic signed [W-1:0]      s,
  input  logic        [SHIFTW-1:0] a,
  input  logic                     pass,
  output logic signed [W-1:0]      y
);
  logic signed [W:0] diff, step, sum;
  logic        [31:0] amt;
  logic               unused_msb;

  // One guard bit on the difference keeps (x - s) exact. The sum lands back in W bits.
  always_comb begin
    amt  = (32'(a) > 32'(W)) ? 32'(W) : 32'(a);
    diff = {x[W-1], x} - {s[W-1], s};
    step = diff >>> amt;
    sum  = {s[W-1], s} + step;
    y    = (pass || a == '0) ? x : sum[W-1:0];
  end

  assign unused_msb = sum[W];
endmodule

// Top level: start and done handshake, stage sequencing, and the state file.
module iir_cascade #(
  parameter int DATAWIDTH = 16,
  parameter int STAGES    = 2,
  parameter int SHIFTW    = 4,
  parameter int GUARD     = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        once,
  input  logic signed [DATAWIDTH-1:0] in,
  input  logic [STAGES*SHIFTW-1:0]    shifts,
  input  logic [STAGES-1:0]           bypass,
  output logic                        busy,
  output logic                        done,
  output logic signed [DATAWIDTH-1:0] out
);
  localparam int W  = DATAWIDTH + GUARD;
  localparam int KW = (STAGES > 1) ? $clog2(STAGES) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                         state, state_nx;
  logic [KW-1:0]                  k, k_nx;
  logic                           last, accept;
  logic [STAGES-1:0][SHIFTW-1:0]  sh_q;
  logic [STAGES-1:0]              byp_q;
  logic [STAGES-1:0][W-1:0]       s;
  logic signed [W-1:0]            x, y;

  assign last   = (state == RUN) && (k == KW'(STAGES - 1));
  // A new sample may enter while idle, or on the final-stage edge for back-to-back operation.
  assign accept = once && !clear && ((state == IDLE) || last);

  iir_stage_alu #(.W(W), .SHIFTW(SHIFTW)) u_alu (
    .x    (x),
    .s    ($signed(s[k])),
    .a    (sh_q[k]),
    .pass (byp_q[k]),
    .y    (y)
  );

  // Next-state logic: clear wins, then acceptance, then the stage walk.
  always_comb begin
    state_nx = state;
    k_nx     = k;
    if (clear) begin
      state_nx = IDLE;
      k_nx     = '0;
    end else if (accept) begin
      state_nx = RUN;
      k_nx     = '0;
    end else if (state == RUN) begin
      if (last) begin
        state_nx = IDLE;
        k_nx     = '0;
      end else begin
        k_nx = k + 1'b1;
      end
    end
  end

  // State register. busy is registered, so it follows the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      k     <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      k     <= k_nx;
      busy  <= (state_nx == RUN);
    end
  end

  // Datapath: stage update, output register, and sample and coefficient capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s     <= '0;
      x     <= '0;
      out   <= '0;
      done  <= 1'b0;
      sh_q  <= '0;
      byp_q <= '0;
    end else if (clear) begin
      s    <= '0;
      x    <= '0;
      out  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == RUN) begin
        s[k] <= y;
        x    <= y;
        if (last) begin
          // Dropping the guard bits of a two's complement value is a floor shift.
          out  <= y[W-1:GUARD];
          done <= 1'b1;
        end
      end
      // This assignment comes last, so a sample accepted on the final edge overrides the x write-back.
      if (accept) begin
        x     <= W'(in) <<< GUARD;
        sh_q  <= shifts;
        byp_q <= bypass;
      end
    end
  end
endmodule
